// File: rtl/acquisition_scheduler.sv
// Frame-capture sequencer for the S15611 acquisition path: issues one-cycle frame
// triggers in single, burst or continuous mode and watches the outgoing AXIS stream.
module acquisition_scheduler #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd4000000,
  parameter logic [31:0] MIN_PERIOD     = 32'd2048
) (
  input  logic        master_clock,
  input  logic        resetn,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic [1:0]  cfg_mode,
  input  logic [15:0] cfg_burst_len,
  input  logic [31:0] cfg_period,
  input  logic        dma_ready,
  input  logic        mon_tvalid,
  input  logic        mon_tready,
  input  logic        mon_tlast,
  output logic        frame_trigger,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count,
  output logic        overrun_err,
  output logic        timeout_err,
  output logic [2:0]  dbg_state
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TMR_W = 32;

  localparam logic [1:0] MODE_SINGLE     = 2'd0;
  localparam logic [1:0] MODE_BURST      = 2'd1;
  localparam logic [1:0] MODE_CONTINUOUS = 2'd2;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    TRIGGER     = 3'd1,
    WAIT_FRAME  = 3'd2,
    WAIT_PERIOD = 3'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         mode_q;
  logic [TMR_W-1:0]   period_q;
  logic [CNT_W-1:0]   remaining;
  logic [TMR_W-1:0]   period_cnt;
  logic [TMR_W-1:0]   timeout_cnt;
  logic               stop_pending;

  logic               frame_end;
  logic               continuous;
  logic               start_ok;
  logic               rem_last;
  logic [TMR_W-1:0]   period_last;
  logic [TMR_W-1:0]   period_cnt_nxt;
  logic               period_hit;
  logic               timeout_hit;

  assign frame_end   = mon_tvalid & mon_tready & mon_tlast;
  assign continuous  = (mode_q == MODE_CONTINUOUS);
  assign start_ok    = cmd_start & ~cmd_stop &
                       ~((cfg_mode == MODE_BURST) && (cfg_burst_len == CNT_W'(0)));
  assign rem_last    = ~continuous && (remaining == CNT_W'(1));
  assign timeout_hit = (timeout_cnt == TIMEOUT_CYCLES - TMR_W'(1));

  // period_hit marks the edge at which period_cnt reaches (or sits at) period-1,
  // which is what makes trigger-to-trigger spacing exactly period clocks.
  assign period_last    = period_q - TMR_W'(1);
  assign period_cnt_nxt = (period_cnt == period_last) ? period_cnt : period_cnt + TMR_W'(1);
  assign period_hit     = (period_cnt_nxt == period_last);

  assign dbg_state = state;

  // Next-state decision
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = TRIGGER;
      end
      TRIGGER: begin
        if (cmd_stop)       state_nxt = IDLE;
        else if (dma_ready) state_nxt = WAIT_FRAME;
        else if (rem_last)  state_nxt = IDLE;
        else                state_nxt = WAIT_PERIOD;
      end
      WAIT_FRAME: begin
        if (frame_end) begin
          if (stop_pending || cmd_stop || rem_last) state_nxt = IDLE;
          else if (period_hit)                      state_nxt = TRIGGER;
          else                                      state_nxt = WAIT_PERIOD;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      WAIT_PERIOD: begin
        if (cmd_stop)        state_nxt = IDLE;
        else if (period_hit) state_nxt = TRIGGER;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, sequencing counters and registered outputs
  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      mode_q        <= MODE_SINGLE;
      period_q      <= '0;
      remaining     <= '0;
      period_cnt    <= '0;
      timeout_cnt   <= '0;
      stop_pending  <= 1'b0;
      frame_trigger <= 1'b0;
      busy          <= 1'b0;
      frame_count   <= '0;
      drop_count    <= '0;
      overrun_err   <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      frame_trigger <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            mode_q       <= (cfg_mode == MODE_CONTINUOUS) ? MODE_CONTINUOUS :
                            (cfg_mode == MODE_BURST)      ? MODE_BURST : MODE_SINGLE;
            period_q     <= (cfg_period < MIN_PERIOD) ? MIN_PERIOD : cfg_period;
            remaining    <= (cfg_mode == MODE_BURST) ? cfg_burst_len : CNT_W'(1);
            frame_count  <= '0;
            drop_count   <= '0;
            overrun_err  <= 1'b0;
            timeout_err  <= 1'b0;
            stop_pending <= 1'b0;
          end
        end
        TRIGGER: begin
          period_cnt  <= '0;
          timeout_cnt <= '0;
          if (!cmd_stop) begin
            if (dma_ready) begin
              frame_trigger <= 1'b1;
            end else begin
              if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
              if (!continuous)      remaining  <= remaining - CNT_W'(1);
            end
          end
        end
        WAIT_FRAME: begin
          period_cnt  <= period_cnt_nxt;
          timeout_cnt <= timeout_cnt + TMR_W'(1);
          if (cmd_stop) stop_pending <= 1'b1;
          if (frame_end) begin
            frame_count <= frame_count + CNT_W'(1);
            if (!continuous) remaining <= remaining - CNT_W'(1);
          end else begin
            // The period ran out with the frame still in flight.
            if (period_hit)  overrun_err <= 1'b1;
            if (timeout_hit) timeout_err <= 1'b1;
          end
        end
        WAIT_PERIOD: begin
          period_cnt <= period_cnt_nxt;
        end
        default: ;
      endcase

      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      if (state_nxt == IDLE) stop_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acquisition_scheduler.sv
// Directed bench for acquisition_scheduler: single, burst, overrun, drop, timeout,
// bounds and reset scenarios with hand-computed expectations.
module tb_acquisition_scheduler;

  logic        master_clock;
  logic        resetn;
  logic        cmd_start;
  logic        cmd_stop;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_burst_len;
  logic [31:0] cfg_period;
  logic        dma_ready;
  logic        mon_tvalid;
  logic        mon_tready;
  logic        mon_tlast;
  logic        frame_trigger;
  logic        busy;
  logic [15:0] frame_count;
  logic [15:0] drop_count;
  logic        overrun_err;
  logic        timeout_err;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int trig_q[$];

  acquisition_scheduler #(
    .TIMEOUT_CYCLES(32'd3000),
    .MIN_PERIOD    (32'd2048)
  ) dut (
    .master_clock (master_clock),
    .resetn       (resetn),
    .cmd_start    (cmd_start),
    .cmd_stop     (cmd_stop),
    .cfg_mode     (cfg_mode),
    .cfg_burst_len(cfg_burst_len),
    .cfg_period   (cfg_period),
    .dma_ready    (dma_ready),
    .mon_tvalid   (mon_tvalid),
    .mon_tready   (mon_tready),
    .mon_tlast    (mon_tlast),
    .frame_trigger(frame_trigger),
    .busy         (busy),
    .frame_count  (frame_count),
    .drop_count   (drop_count),
    .overrun_err  (overrun_err),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  initial master_clock = 1'b0;
  always #5 master_clock = ~master_clock;

  always @(posedge master_clock) cyc <= cyc + 1;
  always @(negedge master_clock) if (frame_trigger === 1'b1) trig_q.push_back(cyc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge master_clock);
    #1;
  endtask

  task automatic start(input logic [1:0] mode, input logic [15:0] len, input logic [31:0] per);
    cfg_mode = mode; cfg_burst_len = len; cfg_period = per; cmd_start = 1'b1;
    tick(1);
    cmd_start = 1'b0;
  endtask

  task automatic stop_pulse();
    cmd_stop = 1'b1;
    tick(1);
    cmd_stop = 1'b0;
  endtask

  task automatic fend();
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
    tick(1);
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
  endtask

  task automatic wait_trigger(input string tag);
    int n = 0;
    while (frame_trigger !== 1'b1 && n < 6000) begin tick(1); n++; end
    check(tag, 32'(frame_trigger), 32'd1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s);
    int n = 0;
    while (dbg_state !== s && n < 6000) begin tick(1); n++; end
    check(tag, 32'(dbg_state), 32'(s));
  endtask

  initial begin
    resetn = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cfg_mode = 2'd0;
    cfg_burst_len = 16'd0; cfg_period = 32'd0; dma_ready = 1'b1;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    tick(3);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_trig", 32'(frame_trigger), 32'd0);
    check("rst_fcnt", 32'(frame_count), 32'd0);
    check("rst_dcnt", 32'(drop_count), 32'd0);
    check("rst_errs", {30'd0, overrun_err, timeout_err}, 32'd0);
    resetn = 1'b1;
    tick(2);

    // T1 single: 2-cycle start latency, frame end after ~1000 cycles
    trig_q.delete();
    start(2'd0, 16'd0, 32'd5000);
    check("t1_state_trig", 32'(dbg_state), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    tick(1);
    check("t1_latency", 32'(frame_trigger), 32'd1);
    check("t1_state_wf", 32'(dbg_state), 32'd2);
    tick(998);
    check("t1_still_busy", 32'(busy), 32'd1);
    fend();
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_fcnt", 32'(frame_count), 32'd1);
    tick(10);
    check("t1_ntrig", 32'(trig_q.size()), 32'd1);

    // T2 burst of 3, period 5000, frame length 3000
    trig_q.delete();
    start(2'd1, 16'd3, 32'd5000);
    for (int i = 0; i < 3; i++) begin
      wait_trigger("t2_wait");
      tick(2998);
      fend();
    end
    check("t2_state", 32'(dbg_state), 32'd0);
    check("t2_fcnt", 32'(frame_count), 32'd3);
    check("t2_ovr", 32'(overrun_err), 32'd0);
    check("t2_ntrig", 32'(trig_q.size()), 32'd3);
    if (trig_q.size() == 3) begin
      check("t2_space1", 32'(trig_q[1] - trig_q[0]), 32'd5000);
      check("t2_space2", 32'(trig_q[2] - trig_q[1]), 32'd5000);
    end

    // T3 continuous overrun: retrigger right after frame end, then stop mid-frame
    trig_q.delete();
    start(2'd2, 16'd0, 32'd2048);
    for (int i = 0; i < 2; i++) begin
      wait_trigger("t3_wait");
      tick(2498);
      fend();
      check("t3_b2b_state", 32'(dbg_state), 32'd1);
      tick(1);
      check("t3_b2b_trig", 32'(frame_trigger), 32'd1);
    end
    check("t3_ovr", 32'(overrun_err), 32'd1);
    tick(1000);
    stop_pulse();
    check("t3_stop_wf", 32'(dbg_state), 32'd2);
    tick(1000);
    fend();
    check("t3_stop_idle", 32'(dbg_state), 32'd0);
    check("t3_fcnt", 32'(frame_count), 32'd3);
    tick(3000);
    check("t3_ntrig", 32'(trig_q.size()), 32'd3);

    // T4 burst of 4 with the 2nd trigger dropped
    trig_q.delete();
    start(2'd1, 16'd4, 32'd100);
    wait_trigger("t4_wait1");
    tick(99);
    fend();
    dma_ready = 1'b0;
    wait_state("t4_wait_trig", 3'd1);
    tick(1);
    check("t4_drop", 32'(drop_count), 32'd1);
    check("t4_no_pulse", 32'(frame_trigger), 32'd0);
    check("t4_drop_state", 32'(dbg_state), 32'd3);
    dma_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_trigger("t4_wait");
      tick(99);
      fend();
    end
    check("t4_state", 32'(dbg_state), 32'd0);
    check("t4_fcnt", 32'(frame_count), 32'd3);
    check("t4_ntrig", 32'(trig_q.size()), 32'd3);
    if (trig_q.size() == 3) check("t4_space", 32'(trig_q[1] - trig_q[0]), 32'd4096);

    // T5 timeout at exactly TIMEOUT_CYCLES, cleared by the next start
    start(2'd0, 16'd0, 32'd5000);
    wait_trigger("t5_wait");
    tick(2999);
    check("t5_pre_to", 32'(timeout_err), 32'd0);
    check("t5_pre_state", 32'(dbg_state), 32'd2);
    tick(1);
    check("t5_to", 32'(timeout_err), 32'd1);
    check("t5_to_idle", 32'(busy), 32'd0);
    start(2'd0, 16'd0, 32'd5000);
    check("t5_to_clr", 32'(timeout_err), 32'd0);
    wait_trigger("t5_wait2");
    fend();
    check("t5_done", 32'(dbg_state), 32'd0);

    // Burst length 0 is refused
    start(2'd1, 16'd0, 32'd5000);
    check("t5_len0_state", 32'(dbg_state), 32'd0);
    tick(3);
    check("t5_len0_busy", 32'(busy), 32'd0);

    // Period below the minimum is clamped to 2048
    trig_q.delete();
    start(2'd2, 16'd0, 32'd10);
    for (int i = 0; i < 3; i++) begin
      wait_trigger("t5_clamp_wait");
      tick(9);
      fend();
    end
    if (trig_q.size() >= 2) check("t5_clamp", 32'(trig_q[1] - trig_q[0]), 32'd2048);
    stop_pulse();
    check("t5_stop_wp", 32'(dbg_state), 32'd0);
    fend();
    check("t5_fend_idle", 32'(frame_count), 32'd3);
    tick(2100);
    check("t5_ntrig", 32'(trig_q.size()), 32'd3);

    // T6 start while busy is ignored, then async reset mid-frame
    start(2'd0, 16'd0, 32'd5000);
    wait_trigger("t6_wait");
    tick(20);
    start(2'd2, 16'd0, 32'd3000);
    check("t6_busy_start", 32'(dbg_state), 32'd2);
    fend();
    check("t6_single_kept", 32'(dbg_state), 32'd0);
    start(2'd2, 16'd0, 32'd2048);
    wait_trigger("t6_wait2");
    tick(99);
    fend();
    check("t6_fcnt_pre", 32'(frame_count), 32'd1);
    wait_trigger("t6_wait3");
    tick(50);
    #3 resetn = 1'b0;
    #1;
    check("t6_rst_state", 32'(dbg_state), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_fcnt", 32'(frame_count), 32'd0);
    check("t6_rst_trig", 32'(frame_trigger), 32'd0);
    tick(2);
    resetn = 1'b1;
    tick(5);
    check("t6_post_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
